// File: rtl/p_clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package p_clk_div_pkg;

    // Divisors below this value stop a channel.
    localparam int unsigned DIV_MIN = 2;

    // Edge cause for a channel, in rising priority (reset sits above all of these).
    typedef enum logic [1:0] {
        EvCount    = 2'd0,
        EvBoundary = 2'd1,
        EvSync     = 2'd2
    } ev_e;

    // First phase count of the high half: D - floor(D/2). The caller truncates
    // the result to its counter width.
    function automatic logic [31:0] high_start(input logic [31:0] d);
        return d - (d >> 1);
    endfunction

endpackage

// File: rtl/p_clk_div_ch.sv
// One divider channel: phase counter, active divisor, shadow divisor and pending flag.
module p_clk_div_ch
    import p_clk_div_pkg::*;
#(
    parameter int unsigned CNT_WIDTH   = 8,
    parameter int unsigned DEFAULT_DIV = 12
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_sync,
    input  logic                 i_load,
    input  logic [CNT_WIDTH-1:0] i_div,
    output logic                 o_div_clk,
    output logic                 o_tick,
    output logic                 o_pending
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] act_q, act_d;
    logic [CNT_WIDTH-1:0] shadow_q, shadow_d;
    logic                 pending_q, pending_d;
    logic                 div_clk_q, div_clk_d;
    logic                 tick_q, tick_d;
    logic                 stopped;
    logic                 at_last;
    logic                 stopped_d;
    logic [CNT_WIDTH-1:0] hi_start_d;
    ev_e                  ev;

    assign stopped = act_q < CNT_WIDTH'(DIV_MIN);
    assign at_last = !stopped && (cnt_q == act_q - CNT_WIDTH'(1));

    // Select the highest-priority event for this edge.
    always_comb begin
        ev = EvCount;
        if (i_sync) begin
            ev = EvSync;
        end else if (at_last || (stopped && pending_q)) begin
            ev = EvBoundary;
        end
    end

    // Next-state for counter and divisor bookkeeping; a load on an application edge bypasses
    // the shadow register.
    always_comb begin
        cnt_d     = stopped ? '0 : cnt_q + CNT_WIDTH'(1);
        act_d     = act_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        unique case (ev)
            EvSync, EvBoundary: begin
                cnt_d     = '0;
                pending_d = 1'b0;
                if (i_load) begin
                    act_d = i_div;
                end else if (pending_q) begin
                    act_d = shadow_q;
                end
            end
            default: begin
                if (i_load) begin
                    shadow_d  = i_div;
                    pending_d = 1'b1;
                end
            end
        endcase
    end

    // Outputs are decoded from the next counter/divisor so they register in step with cnt.
    always_comb begin
        stopped_d  = act_d < CNT_WIDTH'(DIV_MIN);
        hi_start_d = CNT_WIDTH'(high_start(32'(act_d)));
        div_clk_d  = !stopped_d && (cnt_d >= hi_start_d);
        tick_d     = !stopped_d && (cnt_d == act_d - CNT_WIDTH'(1));
    end

    // State registers with asynchronous reset to the default divisor.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_q     <= '0;
            act_q     <= CNT_WIDTH'(DEFAULT_DIV);
            shadow_q  <= '0;
            pending_q <= 1'b0;
            div_clk_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            act_q     <= act_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            div_clk_q <= div_clk_d;
            tick_q    <= tick_d;
        end
    end

    assign o_div_clk = div_clk_q;
    assign o_tick    = tick_q;
    assign o_pending = pending_q;

endmodule

// File: rtl/p_clk_div_multi.sv
// Multi-channel programmable clock divider: NUM_CH independent channels sharing a sync.
module p_clk_div_multi
    import p_clk_div_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_WIDTH   = 8,
    parameter int unsigned DEFAULT_DIV = 12
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_sync,
    input  logic [NUM_CH-1:0]           i_load,
    input  logic [NUM_CH*CNT_WIDTH-1:0] i_div,
    output logic [NUM_CH-1:0]           o_div_clk,
    output logic [NUM_CH-1:0]           o_tick,
    output logic [NUM_CH-1:0]           o_pending
);

    // One channel per divisor slice.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        p_clk_div_ch #(
            .CNT_WIDTH  (CNT_WIDTH),
            .DEFAULT_DIV(DEFAULT_DIV)
        ) u_ch (
            .i_clk    (i_clk),
            .i_reset  (i_reset),
            .i_sync   (i_sync),
            .i_load   (i_load[k]),
            .i_div    (i_div[k*CNT_WIDTH +: CNT_WIDTH]),
            .o_div_clk(o_div_clk[k]),
            .o_tick   (o_tick[k]),
            .o_pending(o_pending[k])
        );
    end

endmodule

// File: tb/tb_p_clk_div_multi.sv
// Self-checking bench for p_clk_div_multi against a period-position reference model.
module tb_p_clk_div_multi;

    localparam int NCH = 4;
    localparam int W   = 8;
    localparam int DEF = 12;

    logic              i_clk = 1'b0;
    logic              i_reset = 1'b1;
    logic              i_sync = 1'b0;
    logic [NCH-1:0]    i_load = '0;
    logic [NCH*W-1:0]  i_div = '0;
    logic [NCH-1:0]    o_div_clk;
    logic [NCH-1:0]    o_tick;
    logic [NCH-1:0]    o_pending;

    int total = 0;
    int bad   = 0;

    p_clk_div_multi #(
        .NUM_CH     (NCH),
        .CNT_WIDTH  (W),
        .DEFAULT_DIV(DEF)
    ) dut (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_sync   (i_sync),
        .i_load   (i_load),
        .i_div    (i_div),
        .o_div_clk(o_div_clk),
        .o_tick   (o_tick),
        .o_pending(o_pending)
    );

    always #5 i_clk = ~i_clk;

    // Reference model: each channel is described by its divisor and the edge index at which
    // its current period began; position in period is plain modular arithmetic.
    int unsigned cyc;
    int unsigned m_act[NCH];
    int unsigned m_shad[NCH];
    int unsigned m_start[NCH];
    bit          m_pend[NCH];

    function automatic void model_reset();
        cyc = 0;
        for (int k = 0; k < NCH; k++) begin
            m_act[k] = DEF; m_shad[k] = 0; m_start[k] = 0; m_pend[k] = 0;
        end
    endfunction

    function automatic int unsigned m_pos(int k);
        if (m_act[k] < 2) return 0;
        return (cyc - m_start[k]) % m_act[k];
    endfunction

    function automatic void model_edge(bit s, logic [NCH-1:0] ld, logic [NCH*W-1:0] dv);
        int unsigned nc;
        bit stopped, bnd, app;
        nc = cyc + 1;
        for (int k = 0; k < NCH; k++) begin
            stopped = m_act[k] < 2;
            bnd = !stopped && (m_pos(k) == m_act[k] - 1);
            app = s || bnd || (stopped && m_pend[k]);
            if (app) begin
                if (ld[k]) m_act[k] = int'(dv[k*W +: W]);
                else if (m_pend[k]) m_act[k] = m_shad[k];
                m_pend[k] = 0;
                m_start[k] = nc;
            end else begin
                if (ld[k]) begin
                    m_shad[k] = int'(dv[k*W +: W]);
                    m_pend[k] = 1;
                end
                if (stopped) m_start[k] = nc;
            end
        end
        cyc = nc;
    endfunction

    // Expected {div_clk, tick, pending}.
    function automatic logic [3*NCH-1:0] model_out();
        logic [NCH-1:0] c, t, p;
        int unsigned pos;
        for (int k = 0; k < NCH; k++) begin
            p[k] = m_pend[k];
            if (m_act[k] < 2) begin
                c[k] = 1'b0; t[k] = 1'b0;
            end else begin
                pos = m_pos(k);
                c[k] = pos >= m_act[k] - m_act[k] / 2;
                t[k] = pos == m_act[k] - 1;
            end
        end
        return {c, t, p};
    endfunction

    task automatic step(input bit s, input logic [NCH-1:0] ld, input logic [NCH*W-1:0] dv);
        i_sync = s; i_load = ld; i_div = dv;
        @(posedge i_clk);
        model_edge(s, ld, dv);
        #1;
        i_sync = 1'b0; i_load = '0; i_div = '0;
    endtask

    function automatic logic [NCH*W-1:0] div_at(int k, int unsigned d);
        logic [NCH*W-1:0] v;
        v = '0;
        v[k*W +: W] = W'(d);
        return v;
    endfunction

    task automatic release_reset();
        repeat (2) @(posedge i_clk);
        #4;
        i_reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        logic [3*NCH-1:0] got;
        model_reset();
        #2;
        got = {o_div_clk, o_tick, o_pending};
        total++;
        if (got !== '0) begin
            bad++; $display("FAIL reset_hold got=%h want=0", got);
        end
        release_reset();
        got = {o_div_clk, o_tick, o_pending};
        total++;
        if (got !== model_out()) begin
            bad++; $display("FAIL reset_release got=%h want=%h", got, model_out());
        end
    endtask

    task automatic test_default();
        logic [3*NCH-1:0] got;
        for (int i = 0; i < 30; i++) begin
            step(0, '0, '0);
            got = {o_div_clk, o_tick, o_pending};
            total++;
            if (got !== model_out()) begin
                bad++; $display("FAIL default cyc=%0d got=%h want=%h", cyc, got, model_out());
            end
        end
    endtask

    task automatic test_load_mid();
        logic [3*NCH-1:0] got;
        int n = 0;
        while (m_pos(1) != 3 && n < 300) begin step(0, '0, '0); n++; end
        total++;
        if (n >= 300) begin bad++; $display("FAIL load_mid_wait got=timeout want=cnt3"); end
        step(0, 4'b0010, div_at(1, 5));
        total++;
        if (o_pending[1] !== 1'b1) begin
            bad++; $display("FAIL load_mid_pending got=%b want=1", o_pending[1]);
        end
        for (int i = 0; i < 30; i++) begin
            step(0, '0, '0);
            got = {o_div_clk, o_tick, o_pending};
            total++;
            if (got !== model_out()) begin
                bad++; $display("FAIL load_mid cyc=%0d got=%h want=%h", cyc, got, model_out());
            end
        end
    endtask

    task automatic test_overwrite();
        logic [3*NCH-1:0] got;
        int n = 0;
        while (m_pos(2) != 1 && n < 300) begin step(0, '0, '0); n++; end
        step(0, 4'b0100, div_at(2, 7));
        step(0, 4'b0100, div_at(2, 4));
        for (int i = 0; i < 30; i++) begin
            step(0, '0, '0);
            got = {o_div_clk, o_tick, o_pending};
            total++;
            if (got !== model_out()) begin
                bad++; $display("FAIL overwrite cyc=%0d got=%h want=%h", cyc, got, model_out());
            end
        end
        total++;
        if (m_act[2] != 4) begin bad++; $display("FAIL overwrite_div got=%0d want=4", m_act[2]); end
    endtask

    task automatic test_stop();
        logic [3*NCH-1:0] got;
        int n = 0;
        step(0, 4'b1000, div_at(3, 1));
        while (m_pend[3] && n < 300) begin
            step(0, '0, '0); n++;
            got = {o_div_clk, o_tick, o_pending};
            total++;
            if (got !== model_out()) begin
                bad++; $display("FAIL stop_wait cyc=%0d got=%h want=%h", cyc, got, model_out());
            end
        end
        for (int i = 0; i < 10; i++) begin
            step(0, '0, '0);
            total++;
            if ({o_div_clk[3], o_tick[3]} !== 2'b00) begin
                bad++; $display("FAIL stopped_out got=%b%b want=00", o_div_clk[3], o_tick[3]);
            end
        end
        step(0, 4'b1000, div_at(3, 2));
        for (int i = 0; i < 10; i++) begin
            step(0, '0, '0);
            got = {o_div_clk, o_tick, o_pending};
            total++;
            if (got !== model_out()) begin
                bad++; $display("FAIL restart cyc=%0d got=%h want=%h", cyc, got, model_out());
            end
        end
    endtask

    task automatic test_coincident();
        logic [3*NCH-1:0] got;
        int n = 0;
        while (m_pos(0) != m_act[0] - 1 && n < 300) begin step(0, '0, '0); n++; end
        step(0, 4'b0001, div_at(0, 6));
        for (int i = 0; i < 15; i++) begin
            got = {o_div_clk, o_tick, o_pending};
            total++;
            if (o_pending[0] !== 1'b0 || got !== model_out()) begin
                bad++; $display("FAIL coincident cyc=%0d got=%h want=%h", cyc, got, model_out());
            end
            step(0, '0, '0);
        end
    endtask

    task automatic test_sync();
        logic [NCH*W-1:0] dv;
        logic [3*NCH-1:0] got;
        int all_ticks = 0;
        dv = div_at(0, 12) | div_at(1, 5) | div_at(2, 3) | div_at(3, 8);
        step(0, 4'b1111, dv);
        step(1, '0, '0);
        total++;
        if ({o_div_clk, o_tick} !== '0) begin
            bad++; $display("FAIL sync_low got=%h want=0", {o_div_clk, o_tick});
        end
        for (int i = 1; i <= 130; i++) begin
            step(0, '0, '0);
            got = {o_div_clk, o_tick, o_pending};
            if (o_tick === 4'hf) all_ticks++;
            total++;
            if (got !== model_out()) begin
                bad++; $display("FAIL sync_run i=%0d got=%h want=%h", i, got, model_out());
            end
            if (i == 119) begin
                total++;
                if (o_tick !== 4'hf) begin
                    bad++; $display("FAIL sync_lcm got=%h want=f", o_tick);
                end
            end
        end
        total++;
        if (all_ticks != 1) begin
            bad++; $display("FAIL sync_coinc_count got=%0d want=1", all_ticks);
        end
    endtask

    task automatic test_random();
        logic [3*NCH-1:0] got;
        logic [NCH-1:0]   ld;
        logic [NCH*W-1:0] dv;
        bit s;
        for (int i = 0; i < 400; i++) begin
            ld = '0; dv = '0;
            for (int k = 0; k < NCH; k++) begin
                if ($urandom_range(0, 5) == 0) ld[k] = 1'b1;
                dv[k*W +: W] = W'($urandom_range(0, 20));
            end
            s = ($urandom_range(0, 39) == 0);
            step(s, ld, dv);
            got = {o_div_clk, o_tick, o_pending};
            total++;
            if (got !== model_out()) begin
                bad++; $display("FAIL random i=%0d got=%h want=%h", i, got, model_out());
            end
        end
    endtask

    task automatic test_async_reset();
        logic [3*NCH-1:0] got;
        step(0, 4'b0010, div_at(1, 9));
        #3;
        i_reset = 1'b1;
        #1;
        got = {o_div_clk, o_tick, o_pending};
        total++;
        if (got !== '0) begin
            bad++; $display("FAIL async_reset got=%h want=0", got);
        end
        release_reset();
        for (int i = 0; i < 30; i++) begin
            step(0, '0, '0);
            got = {o_div_clk, o_tick, o_pending};
            total++;
            if (got !== model_out() || o_pending !== '0) begin
                bad++; $display("FAIL post_reset cyc=%0d got=%h want=%h", cyc, got, model_out());
            end
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_load_mid();
        test_overwrite();
        test_stop();
        test_coincident();
        test_sync();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/p_clk_div_multi.md
Name: p_clk_div_multi

Overview:
Multi-channel programmable clock divider, successor to the fixed single-channel divider.
- Each of NUM_CH channels divides i_clk by a runtime-loadable integer D, odd or even.
- Each channel produces a registered divided-clock level and a one-cycle period-end tick.
- Divisor changes are glitch-free and take effect only at a period boundary.
- A global sync restarts all channels phase-aligned.
- Feeds timing and enable generation in the clock/timer subsystem.

Parameters:
NUM_CH, 4, number of independent divider channels (1..16)
CNT_WIDTH, 8, width of divisor and phase counter per channel
DEFAULT_DIV, 12, divisor every channel uses after reset; must be < 2**CNT_WIDTH

Ports:
i_clk  input  1  single clock; all logic on rising edge
i_reset  input  1  asynchronous, active-high reset
i_sync  input  1  synchronous global phase restart, one-cycle pulse
i_load  input  NUM_CH  per-channel divisor load strobe
i_div  input  NUM_CH*CNT_WIDTH  divisor values; channel k in bits [k*CNT_WIDTH +: CNT_WIDTH]
o_div_clk  output  NUM_CH  divided clock level per channel
o_tick  output  NUM_CH  one-cycle pulse in the last cycle of each period
o_pending  output  NUM_CH  loaded divisor waiting for the next boundary

Behaviour:
- Reset (async, any time, including mid-period or with a load pending):
  - active_div = DEFAULT_DIV, cnt = 0, shadow = 0, pending = 0.
  - o_div_clk = 0, o_tick = 0, o_pending = 0.
- Running channel (active_div >= 2), each edge:
  - cnt <= (cnt == active_div-1) ? 0 : cnt+1.
- Outputs are registered and updated together with cnt, so each one is a pure decode of the current cnt:
  - o_div_clk = 1 iff cnt >= active_div - floor(active_div/2).
  - o_tick = 1 iff cnt == active_div-1.
  - Even D: 50% duty. D=12 gives cnt 0..5 low, 6..11 high.
  - Odd D: low one cycle longer than high. D=3 gives low, low, high.
  - o_div_clk rises on the cycle after reset release + (D - floor(D/2)) cycles.
- Stopped channel (active_div of 0 or 1):
  - cnt held at 0; o_div_clk = 0, o_tick = 0.
- Load:
  - i_load[k] captures i_div slice k into shadow[k] and sets pending[k].
  - A later load before application overwrites shadow; only the last value is used.
- Application of a pending load, at the edge where any of the following holds:
  - a) channel running and cnt == active_div-1 (boundary);
  - b) channel stopped (next edge after the load);
  - c) i_sync.
  - On application: active_div <= shadow, cnt <= 0, pending <= 0.
- Load coinciding with an application edge: the new i_div value is applied directly (bypass) and pending stays 0.
- Loading D < 2 stops the channel at the boundary. Output is already low at cnt 0, so there is no glitch.
- o_pending[k] equals pending[k]. It rises one cycle after the load and falls on the application edge.
- i_sync:
  - All channels: cnt <= 0, o_div_clk <= 0, o_tick <= 0; pending loads are applied.
  - Priority: reset > sync > boundary > count.
- No high or low phase is ever shorter than the floor(D/2) of the divisor active for that period. Divisor changes never truncate a period, except via i_sync or reset.

Decomposition:
- Shared package p_clk_div_pkg holds:
  - DIV_MIN = 2 (stop threshold);
  - a function giving the high-phase start, D - floor(D/2), at CNT_WIDTH width;
  - the priority encoding constants.
- Natural sub-module: p_clk_div_ch, one channel holding cnt, active_div, shadow and pending. The top level instantiates NUM_CH of them via generate and slices i_div.

Test Plan:
- Reset release, DEFAULT_DIV=12, no loads -> ch0 o_div_clk low 6 cycles / high 6 cycles repeating; o_tick pulses every 12 cycles, coincident with the last high cycle.
- Load D=5 on ch1 at cnt=3 of a 12-period -> o_pending high until the boundary; old period completes 12 cycles; then low 3 / high 2 repeating; tick every 5.
- Load D=7 then D=4 on ch2 within one period -> D=7 never used; after the boundary ch2 runs at period 4, 2/2.
- Load D=1 on ch3 -> at the boundary ch3 output and tick stay 0. Then load D=2 -> applied next edge; toggles low/high every cycle.
- Channels at D=12, 5, 3, 8 free-running; pulse i_sync -> all cnt 0, all outputs low next cycle; o_tick of all four coincides every 120 cycles.
- Assert i_reset asynchronously mid-period with a load pending -> outputs 0 immediately without a clock edge; after release, all channels run at 12, o_pending = 0.
- Load coincident with boundary edge (ch0, D=6) -> o_pending never asserts; the next period is 6 cycles, 3/3.
